// File: rtl/i2c_master_tx.sv
// Write-only I2C master: START, address+W, one data byte per fifo entry, STOP.
// NACK on any byte aborts with STOP. SCL/SDA are open-drain enables; pads live outside.
module i2c_master_tx #(
   parameter int p_WORD_LEN = 8,
   parameter int p_CLK_DIV  = 4
) (
   input  logic                  i_clk,
   input  logic                  i_rst_n,
   input  logic                  i_start,
   input  logic [6:0]            i_addr,
   input  logic                  i_deq_rdy,
   output logic                  o_deq_en,
   input  logic [p_WORD_LEN-1:0] i_deq_data,
   output logic                  o_scl,
   output logic                  o_sda_oe,
   input  logic                  i_sda,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_nack
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_ADDR  = 3'd2;
   localparam logic [2:0] S_ACK_A = 3'd3;
   localparam logic [2:0] S_FETCH = 3'd4;
   localparam logic [2:0] S_DATA  = 3'd5;
   localparam logic [2:0] S_ACK_D = 3'd6;
   localparam logic [2:0] S_STOP  = 3'd7;

   localparam int              QW     = $clog2(p_CLK_DIV);
   localparam logic [QW-1:0]   Q_LAST = QW'(p_CLK_DIV - 1);
   localparam int              MSB    = p_WORD_LEN - 1;

   logic [2:0]            state_reg;
   logic [QW-1:0]         quarter_reg;
   logic [1:0]            phase_reg;
   logic [2:0]            bit_reg;
   logic [p_WORD_LEN-1:0] shift_reg;
   logic                  sda_hold_reg;
   logic                  ack_reg;
   logic                  fetch_wait_reg;
   logic                  nack_reg;

   logic q_last;
   logic bit_end;
   logic timed;
   logic scl_next;
   logic sda_oe_next;

   assign q_last  = (quarter_reg == Q_LAST);
   assign bit_end = q_last && (phase_reg == 2'd3);
   assign timed   = (state_reg != S_IDLE) && (state_reg != S_FETCH);

   // Phase 0 always repeats the previous SDA level so SDA never moves on the SCL falling edge.
   always_comb begin
      scl_next    = 1'b1;
      sda_oe_next = 1'b0;
      case (state_reg)
         S_IDLE: begin
            scl_next    = 1'b1;
            sda_oe_next = 1'b0;
         end
         S_START: begin
            scl_next    = 1'b1;
            sda_oe_next = phase_reg[1];
         end
         S_ADDR, S_DATA: begin
            scl_next    = phase_reg[1];
            sda_oe_next = (phase_reg == 2'd0) ? sda_hold_reg : ~shift_reg[MSB];
         end
         S_ACK_A, S_ACK_D: begin
            scl_next    = phase_reg[1];
            sda_oe_next = (phase_reg == 2'd0) ? sda_hold_reg : 1'b0;
         end
         S_FETCH: begin
            scl_next    = 1'b0;
            sda_oe_next = sda_hold_reg;
         end
         S_STOP: begin
            scl_next    = phase_reg[1];
            sda_oe_next = (phase_reg == 2'd0) ? sda_hold_reg : (phase_reg != 2'd3);
         end
         default: begin
            scl_next    = 1'b1;
            sda_oe_next = 1'b0;
         end
      endcase
   end

   assign o_scl    = scl_next;
   assign o_sda_oe = sda_oe_next;
   assign o_deq_en = (state_reg == S_FETCH) && !fetch_wait_reg && i_deq_rdy;
   assign o_busy   = (state_reg != S_IDLE);
   // Combinational so that i_start in the o_done cycle still sees a non-IDLE state.
   assign o_done   = (state_reg == S_STOP) && bit_end;
   assign o_nack   = nack_reg;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_reg      <= S_IDLE;
         quarter_reg    <= '0;
         phase_reg      <= 2'd0;
         bit_reg        <= 3'd0;
         shift_reg      <= '0;
         sda_hold_reg   <= 1'b0;
         ack_reg        <= 1'b0;
         fetch_wait_reg <= 1'b0;
         nack_reg       <= 1'b0;
      end else begin
         sda_hold_reg <= sda_oe_next;

         // Phase wraps 3->0 at bit end, so every state entry restarts the timer.
         if (timed) begin
            if (q_last) begin
               quarter_reg <= '0;
               phase_reg   <= phase_reg + 2'd1;
            end else begin
               quarter_reg <= quarter_reg + 1'b1;
            end
         end

         case (state_reg)
            S_IDLE: begin
               if (i_start) begin
                  shift_reg <= p_WORD_LEN'({i_addr, 1'b0});
                  nack_reg  <= 1'b0;
                  bit_reg   <= 3'd0;
                  state_reg <= S_START;
               end
            end
            S_START: begin
               if (bit_end) state_reg <= S_ADDR;
            end
            S_ADDR, S_DATA: begin
               if (bit_end) begin
                  shift_reg <= {shift_reg[MSB-1:0], 1'b0};
                  bit_reg   <= bit_reg + 3'd1;
                  if (bit_reg == 3'd7)
                     state_reg <= (state_reg == S_ADDR) ? S_ACK_A : S_ACK_D;
               end
            end
            S_ACK_A, S_ACK_D: begin
               if (q_last && (phase_reg == 2'd2)) ack_reg <= i_sda;
               if (bit_end) begin
                  if (ack_reg) begin
                     nack_reg  <= 1'b1;
                     state_reg <= S_STOP;
                  end else begin
                     state_reg <= S_FETCH;
                  end
               end
            end
            S_FETCH: begin
               if (fetch_wait_reg) begin
                  shift_reg      <= i_deq_data;
                  fetch_wait_reg <= 1'b0;
                  state_reg      <= S_DATA;
               end else if (i_deq_rdy) begin
                  fetch_wait_reg <= 1'b1;
               end else begin
                  state_reg <= S_STOP;
               end
            end
            S_STOP: begin
               if (bit_end) state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

endmodule
